// File: rtl/ram_pkg.sv
// Shared types for the DRAM-to-SRAM cycle decoder: FSM states, SRAM strobe
// bundle and the helper that forms the strobes of an active access.
package ram_pkg;

  localparam int ROW_BITS_DEF = 9;
  localparam int STB_W        = 5;   // ras, casu, casl, we, oe

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ROW     = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_PAGE    = 3'd3,
    ST_REFRESH = 3'd4
  } state_e;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic ub_n;
    logic lb_n;
  } sram_stb_t;

  localparam sram_stb_t STB_IDLE = '1;

  // Writes keep OE high; reads follow the bus OE. Byte lanes follow their own CAS.
  function automatic sram_stb_t access_stb(input logic we_n, input logic casu_n,
                                           input logic casl_n, input logic oe_n);
    sram_stb_t s;
    s.ce_n = 1'b0;
    s.we_n = we_n;
    s.oe_n = we_n ? oe_n : 1'b1;
    s.ub_n = casu_n;
    s.lb_n = casl_n;
    return s;
  endfunction

endpackage

// File: rtl/sync_bus.sv
// N-stage, WIDTH-bit flop synchroniser with a parameterised reset value.
module sync_bus #(
  parameter int               STAGES  = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] stg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_q <= {STAGES{RST_VAL}};
    end else begin
      stg_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  assign q_o = stg_q[STAGES-1];

endmodule

// File: rtl/dram_cycle_decoder.sv
// Amiga DRAM bus front end: synchronises RAS/CAS/WE/OE and the muxed address,
// classifies read / early-write / CBR refresh and drives registered SRAM strobes.
module dram_cycle_decoder
  import ram_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ROW_BITS    = ROW_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ROW_BITS-1:0]   ain,
  input  logic                  ras_n,
  input  logic                  casu_n,
  input  logic                  casl_n,
  input  logic                  we_n,
  input  logic                  oe_n,
  output logic [2*ROW_BITS-1:0] sram_addr,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_ub_n,
  output logic                  sram_lb_n,
  output logic                  busy,
  output logic                  refresh_pulse
);

  logic [STB_W-1:0]    stb_s;
  logic [ROW_BITS-1:0] ain_s;
  logic                ras_s, casu_s, casl_s, we_s, oe_s;

  sync_bus #(.STAGES(SYNC_STAGES), .WIDTH(STB_W), .RST_VAL({STB_W{1'b1}})) u_sync_stb (
    .clk (clk),
    .rst (rst),
    .d_i ({ras_n, casu_n, casl_n, we_n, oe_n}),
    .q_o (stb_s)
  );

  sync_bus #(.STAGES(SYNC_STAGES), .WIDTH(ROW_BITS), .RST_VAL('0)) u_sync_ain (
    .clk (clk),
    .rst (rst),
    .d_i (ain),
    .q_o (ain_s)
  );

  assign {ras_s, casu_s, casl_s, we_s, oe_s} = stb_s;

  state_e                  state_q;
  sram_stb_t               stb_q;
  logic [2*ROW_BITS-1:0]   addr_q;
  logic [ROW_BITS-1:0]     row_q;
  logic                    we_lat_q;
  logic                    busy_q, refresh_q;
  logic                    ras_prev_q, cas_any_prev_q;
  logic                    armed_q;
  logic [SYNC_STAGES:0]    vld_pipe_q;

  logic cas_any, ras_fall, flush_done;

  assign cas_any    = ~casu_s | ~casl_s;
  assign ras_fall   = ras_prev_q & ~ras_s;
  // Synchroniser contents are only trusted once real input has filled every stage.
  assign flush_done = vld_pipe_q[SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      stb_q          <= STB_IDLE;
      addr_q         <= '0;
      row_q          <= '0;
      we_lat_q       <= 1'b1;
      busy_q         <= 1'b0;
      refresh_q      <= 1'b0;
      ras_prev_q     <= 1'b1;
      cas_any_prev_q <= 1'b0;
      armed_q        <= 1'b0;
      vld_pipe_q     <= '0;
    end else begin
      vld_pipe_q     <= {vld_pipe_q[SYNC_STAGES-1:0], 1'b1};
      ras_prev_q     <= ras_s;
      cas_any_prev_q <= cas_any;
      busy_q         <= ~ras_s;
      // After reset a RAS cycle already in flight is ignored until RAS is seen high.
      armed_q        <= armed_q | (flush_done & ras_s);
      refresh_q      <= 1'b0;
      stb_q          <= STB_IDLE;

      case (state_q)
        ST_IDLE: begin
          if (armed_q && ras_fall) begin
            // CBR only if CAS was already low before RAS fell; a same-clock fall is RAS-first.
            if (cas_any && cas_any_prev_q) begin
              refresh_q <= 1'b1;
              state_q   <= ST_REFRESH;
            end else begin
              row_q   <= ain_s;
              state_q <= ST_ROW;
            end
          end
        end
        ST_ROW, ST_PAGE: begin
          if (ras_s) begin
            state_q <= ST_IDLE;
          end else if (cas_any) begin
            addr_q   <= {ain_s, row_q};
            we_lat_q <= we_s;
            stb_q    <= access_stb(we_s, casu_s, casl_s, oe_s);
            state_q  <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (ras_s) begin
            state_q <= ST_IDLE;
          end else if (!cas_any) begin
            state_q <= ST_PAGE;
          end else begin
            stb_q <= access_stb(we_lat_q, casu_s, casl_s, oe_s);
          end
        end
        ST_REFRESH: begin
          if (ras_s && !cas_any) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sram_addr     = addr_q;
  assign sram_ce_n     = stb_q.ce_n;
  assign sram_oe_n     = stb_q.oe_n;
  assign sram_we_n     = stb_q.we_n;
  assign sram_ub_n     = stb_q.ub_n;
  assign sram_lb_n     = stb_q.lb_n;
  assign busy          = busy_q;
  assign refresh_pulse = refresh_q;

endmodule

// File: tb/tb_dram_cycle_decoder.sv
// Scoreboard bench: stimulus pushes expected SRAM accesses / refreshes, a
// negedge monitor pops and compares whenever CE falls or a refresh pulse appears.
module tb_dram_cycle_decoder;

  localparam int RB  = 9;
  localparam int SS  = 2;
  localparam int LAT = SS + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RB-1:0] ain = '0;
  logic          ras_n = 1'b1, casu_n = 1'b1, casl_n = 1'b1, we_n = 1'b1, oe_n = 1'b1;
  logic [2*RB-1:0] sram_addr;
  logic          sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, busy, refresh_pulse;

  dram_cycle_decoder #(.SYNC_STAGES(SS), .ROW_BITS(RB)) dut (
    .clk(clk), .rst(rst), .ain(ain), .ras_n(ras_n), .casu_n(casu_n), .casl_n(casl_n),
    .we_n(we_n), .oe_n(oe_n), .sram_addr(sram_addr), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n), .busy(busy), .refresh_pulse(refresh_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit              is_ref;
    logic [2*RB-1:0] addr;
    logic [3:0]      stb;   // {we_n, oe_n, ub_n, lb_n}
    int              at;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural expectation of one column access: address is {col,row}, the
  // access type is fixed at the CAS fall, reads present OE, writes hold OE high.
  task automatic push_acc(input logic [2*RB-1:0] addr, input bit we, input bit oe,
                          input logic [1:0] mask);
    exp_t e;
    e.is_ref = 1'b0;
    e.addr   = addr;
    e.stb    = {we, (we ? oe : 1'b1), ~mask[1], ~mask[0]};
    e.at     = cyc + LAT;
    exp_q.push_back(e);
  endtask

  task automatic push_ref();
    exp_t e;
    e.is_ref = 1'b1;
    e.addr   = '0;
    e.stb    = '1;
    e.at     = cyc + LAT;
    exp_q.push_back(e);
  endtask

  task automatic ras_open(input logic [RB-1:0] row);
    ain = row; tick(1);
    ras_n = 1'b0; tick(3);
  endtask

  task automatic ras_close();
    ras_n = 1'b1; tick(4);
  endtask

  // One CAS cycle inside an open RAS; mask bit1 = upper, bit0 = lower.
  task automatic do_cas(input logic [RB-1:0] col, input logic [1:0] mask, input bit we,
                        input bit oe, input logic [2*RB-1:0] exp_addr, input int hold);
    ain = col; we_n = we; oe_n = oe; tick(1);
    casu_n = ~mask[1]; casl_n = ~mask[0];
    push_acc(exp_addr, we, oe, mask);
    tick(hold);
    casu_n = 1'b1; casl_n = 1'b1; tick(2);
    we_n = 1'b1; oe_n = 1'b1; tick(1);
  endtask

  task automatic do_refresh();
    casu_n = 1'b0; casl_n = 1'b0; tick(3);
    ras_n = 1'b0;
    push_ref();
    tick(5);
    check("refresh_busy_held", busy, 1'b1);
    ras_n = 1'b1; tick(1);
    casu_n = 1'b1; casl_n = 1'b1; tick(5);
  endtask

  // Monitor
  bit ce_prev = 1'b1;
  bit rp_prev = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (ce_prev && !sram_ce_n) begin
        if (exp_q.size() == 0) begin
          check("unexpected_access_addr", sram_addr, '1);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", {refresh_pulse, sram_ce_n}, e.is_ref ? 2'b11 : 2'b00);
          check("acc_addr", sram_addr, e.addr);
          check("acc_strobes", {sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}, e.stb);
          check("acc_latency", cyc, e.at);
        end
      end
      if (refresh_pulse) begin
        check("refresh_one_clock", rp_prev, 1'b0);
        if (!rp_prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_refresh", refresh_pulse, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("event_kind", {refresh_pulse, sram_ce_n}, e.is_ref ? 2'b11 : 2'b00);
            check("ref_latency", cyc, e.at);
            check("ref_busy_strobes", {busy, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n},
                  6'b111111);
          end
        end
      end
    end
    ce_prev <= sram_ce_n;
    rp_prev <= refresh_pulse;
  end

  initial begin
    logic [RB-1:0] row, col;
    logic [1:0]    mask;
    bit            we, oe;
    int            npg;

    tick(3);
    check("reset_state",
          {sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, busy, refresh_pulse},
          {18'h0, 5'b11111, 2'b00});
    rst = 1'b0; tick(6);

    // Word read then fast-page columns
    ras_open(9'h0AF);
    do_cas(9'h09A, 2'b11, 1'b1, 1'b0, 18'h134AF, 4);
    do_cas(9'h09B, 2'b10, 1'b1, 1'b0, 18'h136AF, 4);
    do_cas(9'h09C, 2'b11, 1'b1, 1'b0, 18'h138AF, 4);
    ras_close();

    // Early write, lower byte; WE rising mid-access is ignored
    ras_open(9'h001);
    ain = 9'h002; we_n = 1'b0; tick(1);
    casl_n = 1'b0;
    push_acc(18'h00401, 1'b0, 1'b1, 2'b01);
    tick(LAT + 1);
    we_n = 1'b1; tick(LAT + 1);
    check("we_fixed_at_cas", {sram_ce_n, sram_we_n, sram_oe_n}, 3'b001);
    casl_n = 1'b1; tick(3);
    ras_close();

    // Late second CAS: lower byte joins an upper-only access
    ras_open(9'h055);
    ain = 9'h033; oe_n = 1'b0; tick(1);
    casu_n = 1'b0;
    push_acc(18'h06655, 1'b1, 1'b0, 2'b10);
    tick(2);
    casl_n = 1'b0; tick(LAT);
    check("late_cas_bytes", {sram_ce_n, sram_ub_n, sram_lb_n}, 3'b000);
    casu_n = 1'b1; casl_n = 1'b1; oe_n = 1'b1; tick(3);
    ras_close();

    // CBR refresh
    do_refresh();

    // RAS rises on the same clock the CAS falls: no access
    ras_open(9'h123);
    ain = 9'h045; tick(1);
    ras_n = 1'b1; casu_n = 1'b0; casl_n = 1'b0; tick(LAT + 2);
    check("abort_idle", {busy, sram_ce_n}, 2'b01);
    casu_n = 1'b1; casl_n = 1'b1; tick(4);

    // Reset during ACCESS, then RAS held low must not start a new cycle
    ras_open(9'h0F0);
    ain = 9'h00F; oe_n = 1'b0; tick(1);
    casu_n = 1'b0; casl_n = 1'b0;
    push_acc(18'h01EF0, 1'b1, 1'b0, 2'b11);
    tick(LAT + 2);
    rst = 1'b1; tick(1);
    check("reset_mid_access",
          {sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, busy, refresh_pulse},
          {18'h0, 5'b11111, 2'b00});
    rst = 1'b0; tick(5);
    casu_n = 1'b1; casl_n = 1'b1; tick(3);
    casu_n = 1'b0; tick(5);
    check("no_access_after_reset", sram_ce_n, 1'b1);
    casu_n = 1'b1; oe_n = 1'b1; tick(2);
    ras_close();
    ras_open(9'h0F1);
    do_cas(9'h00E, 2'b11, 1'b1, 1'b0, 18'h01CF1, 3);
    ras_close();

    // Randomised traffic
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        do_refresh();
      end else begin
        row = RB'($urandom);
        npg = $urandom_range(1, 3);
        ras_open(row);
        for (int p = 0; p < npg; p++) begin
          col  = RB'($urandom);
          mask = 2'($urandom_range(1, 3));
          we   = 1'($urandom);
          oe   = we ? 1'b0 : 1'($urandom);
          do_cas(col, mask, we, oe, {col, row}, $urandom_range(3, 6));
        end
        ras_close();
      end
    end

    tick(10);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
